mem_access_ctrl: RTL and testbench

// Initiator side of the multicycle CPU's word memory port: accepts one load/store request at a time from the control FSM.

---
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Word-port memory access controller for the multicycle CPU.
// Takes one load/store request at a time. It checks the request for size,
// alignment and range errors, then sequences the read, write or
// read-modify-write access on a word-only memory port.
module mem_access_ctrl #(
  parameter int unsigned MEM_WORDS  = 256,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, next_state;
  logic        we_q, sext_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q, wr_word, rdata_q, mem_addr_q;
  logic        accept, bad;
  logic [4:0]  shamt;
  logic [31:0] lane_mask, shifted, load_val, merged;

  assign accept = req && (state == IDLE);

  // Request checks: reserved size, misaligned half/word, word index out of range
  always_comb begin
    bad = 1'b0;
    if (size == 2'b11)                          bad = 1'b1;
    if (size == 2'b01 && addr[0] != 1'b0)       bad = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00)    bad = 1'b1;
    if ({2'b00, addr[31:2]} >= MEM_WORDS)       bad = 1'b1;
  end

  // Lane position of the latched byte/half within the memory word
  always_comb begin
    shamt = '0;
    case (size_q)
      2'b00:   shamt = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
      2'b01:   shamt = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
      default: shamt = '0;
    endcase
  end

  // Load extraction with sign/zero extension, and merge word for sub-word stores
  always_comb begin
    shifted   = mem_rdata >> shamt;
    lane_mask = (size_q == 2'b00) ? 32'h0000_00FF :
                (size_q == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    case (size_q)
      2'b00:   load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
    merged = (mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad)                             next_state = DONE;
          else if (!we || size != 2'b10)       next_state = RD;
          else                                 next_state = WR;
        end
      end
      RD:      next_state = we_q ? WR : DONE;
      WR:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, latched request fields, MDR and write-data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      wr_word    <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        off_q   <= addr[1:0];
        wdata_q <= wdata;
        wr_word <= wdata;
        err_q   <= bad;
        if (!bad) mem_addr_q <= {2'b00, addr[31:2]};
      end
      if (state == RD) begin
        if (we_q) wr_word <= merged;
        else      rdata_q <= load_val;
      end
    end
  end

  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);
  assign mem_wdata = (state == WR) ? wr_word : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a 256-word behavioural memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  mem_access_ctrl #(.MEM_WORDS(256), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory with a preload port
  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  assign mem_rdata = (mem_read && mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pl_we) mem[pl_idx] <= pl_val;
  end

  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_err", {31'b0, err}, {31'b0, e.err});
        check("done_rdata", rdata, e.rdata);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_we  = 1'b1;
    @(negedge clk);
    pl_we  = 1'b0;
  endtask

  // Present one request while ready; leaves at the negedge after acceptance
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e, input logic [31:0] rexp, input int lat, input bit push);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    if (push) sb.push_back('{e, rexp, cyc + lat});
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, k;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10; sext = 1'b0;
    addr = '0; wdata = '0;
    for (int unsigned i = 0; i < 256; i++) poke(i[7:0], 32'h0);
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word load
    poke(8'd2, 32'hDEADBEEF);
    rd0 = rd_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b1);
    check("wl_mem_read", {31'b0, mem_read}, 32'd1);
    check("wl_mem_addr", mem_addr, 32'd2);
    drain();
    check("wl_read_cycles", rd_cnt - rd0, 32'd1);

    // Byte loads with sign and zero extension
    poke(8'd2, 32'h12F45678);
    issue(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b0, 32'hFFFFFFF4, 2, 1'b1);
    drain();
    issue(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b0, 32'h000000F4, 2, 1'b1);
    drain();

    // Half store via read-modify-write
    poke(8'd3, 32'h11223344);
    wr0 = wr_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'hE, 32'h0000ABCD, 1'b0, 32'h000000F4, 3, 1'b1);
    check("hs_rd_phase", {30'b0, mem_read, mem_write}, 32'd2);
    @(negedge clk);
    check("hs_wr_phase", {30'b0, mem_read, mem_write}, 32'd1);
    check("hs_mem_wdata", mem_wdata, 32'h1122ABCD);
    check("hs_mem_addr", mem_addr, 32'd3);
    drain();
    check("hs_mem3", mem[3], 32'h1122ABCD);
    check("hs_write_cycles", wr_cnt - wr0, 32'd1);

    // Further sub-word and word vectors
    issue(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 1'b0, 32'hFFFFABCD, 2, 1'b1);
    drain();
    issue(1'b0, 2'b00, 1'b0, 32'hF, 32'h0, 1'b0, 32'h000000CD, 2, 1'b1);
    drain();
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 32'h000000CD, 2, 1'b1);
    drain();
    check("ws_mem8", mem[8], 32'hCAFEF00D);
    poke(8'd4, 32'h01020304);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, 1'b0, 32'h000000CD, 3, 1'b1);
    drain();
    check("bs_mem4", mem[4], 32'h015A0304);

    // Error cases: no strobes, rdata unchanged
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678, 1'b1, 32'h000000CD, 1, 1'b1);
    drain();
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 32'h000000CD, 1, 1'b1);
    drain();
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b1, 32'h000000CD, 1, 1'b1);
    drain();
    issue(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 1'b1, 32'h000000CD, 1, 1'b1);
    drain();
    issue(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h77777777, 1'b0, 32'h000000CD, 2, 1'b1);
    drain();
    check("err_no_reads", rd_cnt - rd0, 32'd0);
    check("err_writes_only_last", wr_cnt - wr0, 32'd1);
    check("last_word_mem255", mem[255], 32'h77777777);

    // Reset during RD of a sub-word store
    poke(8'd9, 32'h55667788);
    wr0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 32'h24, 32'h00000099, 1'b0, 32'h0, 3, 1'b0);
    check("abort_in_rd", {31'b0, mem_read}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_no_write", {31'b0, mem_write}, 32'd0);
    check("abort_ready", {31'b0, ready}, 32'd1);
    check("abort_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_write_cycles", wr_cnt - wr0, 32'd0);
    check("abort_mem9", mem[9], 32'h55667788);

    // req held high across three word loads
    poke(8'd5, 32'hA5A50001);
    rd0 = rd_cnt;
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h14; wdata = '0;
    k = cyc;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 32'hA5A50001, k + 2 + 3 * i});
    repeat (9) @(negedge clk);
    req = 1'b0;
    drain();
    check("held_req_reads", rd_cnt - rd0, 32'd3);

    check("never_both_strobes", both_cnt, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
